// File: rtl/ysyx_23060240_exec_ctrl.sv
// ysyx_23060240_exec_ctrl: multi-cycle FETCH/EXEC/MEM/COMMIT sequencer with bus-error and watchdog faults
module ysyx_23060240_exec_ctrl #(
  parameter int TIMEOUT = 1024,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ifu_rvalid,
  input  logic [1:0]       ifu_rresp,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             halt_req,
  input  logic             lsu_done,
  input  logic [1:0]       lsu_resp,
  output logic             fetch_req,
  output logic             inst_valid,
  output logic             lsu_rd_req,
  output logic             lsu_wr_req,
  output logic             commit,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [2:0]       state,
  output logic [RET_W-1:0] retired
);
  localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, COMMIT, HALT, FAULT} state_t;
  state_t st, nxt;
  logic first, is_wr, halt_pend, wd_exp;
  logic [1:0] cause;
  logic [WD_W-1:0] wd;
  assign state      = st;
  assign wd_exp     = (TIMEOUT != 0) && (wd == WD_W'(TIMEOUT - 1));
  assign fetch_req  = st == FETCH && first;
  assign lsu_rd_req = st == MEM && first && !is_wr;
  assign lsu_wr_req = st == MEM && first && is_wr;
  assign commit     = st == COMMIT;
  // A done pulse is checked before expiry so it wins a same-cycle race with the watchdog.
  always_comb begin
    nxt   = st;
    cause = fault_cause;
    case (st)
      IDLE: nxt = FETCH;
      FETCH: begin
        if (ifu_rvalid) begin
          nxt   = ifu_rresp == 2'b00 ? EXEC : FAULT;
          cause = 2'b01;
        end else if (wd_exp) begin
          nxt   = FAULT;
          cause = 2'b11;
        end
      end
      EXEC: begin
        nxt   = is_load && is_store ? FAULT : (is_load || is_store) ? MEM : COMMIT;
        cause = 2'b00;
      end
      MEM: begin
        if (lsu_done) begin
          nxt   = lsu_resp == 2'b00 ? COMMIT : FAULT;
          cause = 2'b10;
        end else if (wd_exp) begin
          nxt   = FAULT;
          cause = 2'b11;
        end
      end
      COMMIT: nxt = halt_pend ? HALT : FETCH;
      default: nxt = st;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st          <= IDLE;
      first       <= 1'b0;
      is_wr       <= 1'b0;
      halt_pend   <= 1'b0;
      wd          <= '0;
      inst_valid  <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      retired     <= '0;
    end else begin
      st          <= nxt;
      first       <= nxt != st;
      wd          <= (nxt != st || !(st == FETCH || st == MEM)) ? '0 : wd + 1'b1;
      is_wr       <= st == EXEC ? is_store : is_wr;
      halt_pend   <= st == EXEC ? halt_req : halt_pend;
      inst_valid  <= nxt == EXEC || nxt == MEM || nxt == COMMIT;
      halted      <= nxt == HALT;
      fault       <= nxt == FAULT;
      fault_cause <= nxt == FAULT ? cause : fault_cause;
      retired     <= retired + RET_W'(st == COMMIT);
    end
  end
endmodule
